// File: rtl/alu_control_mdu.sv
// rtl/alu_control_mdu.sv - registered ALU control decoder with mul/div occupancy FSM
module alu_control_mdu #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  aluop,
  input  logic [31:0] instruction,
  input  logic        stall_in,
  output logic        stall_out,
  output logic        out_valid,
  output logic [3:0]  alu_ctrl,
  output logic [4:0]  shift,
  output logic        shift_var,
  output logic [1:0]  hilo_rd,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic        md_busy,
  output logic        md_done,
  output logic        illegal
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;

  logic               r_out_valid, r_shift_var, r_md_start, r_illegal;
  logic [3:0]         r_alu_ctrl;
  logic [4:0]         r_shift;
  logic [1:0]         r_hilo_rd, r_md_op;

  logic [5:0]         w_funct;
  logic [4:0]         w_shamt;
  logic [3:0]         w_alu_ctrl;
  logic [4:0]         w_shift;
  logic               w_shift_var, w_md_start, w_illegal, w_md_class;
  logic [1:0]         w_hilo_rd, w_md_op;
  logic               w_busy, w_cnt_zero, w_accept;
  logic               w_unused;

  assign w_funct  = instruction[5:0];
  assign w_shamt  = instruction[10:6];
  assign w_unused = ^instruction[31:11];

  always_comb begin
    w_alu_ctrl  = 4'b1111;
    w_shift     = 5'd0;
    w_shift_var = 1'b0;
    w_hilo_rd   = 2'b00;
    w_md_start  = 1'b0;
    w_md_op     = 2'b00;
    w_illegal   = 1'b0;
    w_md_class  = 1'b0;
    case (aluop)
      4'b0000: w_alu_ctrl = 4'b0010;
      4'b0001: w_alu_ctrl = 4'b0110;
      4'b0011: w_alu_ctrl = 4'b0000;
      4'b0100: begin w_alu_ctrl = 4'b0011; w_shift = 5'd16; end
      4'b0101: w_alu_ctrl = 4'b0111;
      4'b0110: w_alu_ctrl = 4'b1000;
      4'b0111: w_alu_ctrl = 4'b0001;
      4'b1000: w_alu_ctrl = 4'b1001;
      4'b0010: begin
        case (w_funct)
          6'd0:  begin w_alu_ctrl = 4'b0011; w_shift = w_shamt; end
          6'd2:  begin w_alu_ctrl = 4'b0100; w_shift = w_shamt; end
          6'd3:  begin w_alu_ctrl = 4'b0101; w_shift = w_shamt; end
          6'd4:  begin w_alu_ctrl = 4'b0011; w_shift_var = 1'b1; end
          6'd6:  begin w_alu_ctrl = 4'b0100; w_shift_var = 1'b1; end
          6'd7:  begin w_alu_ctrl = 4'b0101; w_shift_var = 1'b1; end
          6'd32, 6'd33: w_alu_ctrl = 4'b0010;
          6'd34, 6'd35: w_alu_ctrl = 4'b0110;
          6'd36: w_alu_ctrl = 4'b0000;
          6'd37: w_alu_ctrl = 4'b0001;
          6'd38: w_alu_ctrl = 4'b1000;
          6'd39: w_alu_ctrl = 4'b1100;
          6'd42: w_alu_ctrl = 4'b0111;
          6'd43: w_alu_ctrl = 4'b1001;
          6'd16: begin w_hilo_rd = 2'b01; w_md_class = 1'b1; end
          6'd18: begin w_hilo_rd = 2'b10; w_md_class = 1'b1; end
          6'd24, 6'd25, 6'd26, 6'd27: begin
            w_md_start = 1'b1;
            w_md_op    = w_funct[1:0];
            w_md_class = 1'b1;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // MD-class instructions may enter on the final busy cycle so the unit reloads without a gap
  assign w_busy     = (r_state != S_IDLE);
  assign w_cnt_zero = (r_count == '0);
  assign stall_out  = in_valid & w_md_class & w_busy & ~w_cnt_zero;
  assign w_accept   = in_valid & ~stall_in & ~stall_out;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    if (w_busy && !w_cnt_zero) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
      if (w_accept && w_md_start) begin
        if (w_md_op[1]) begin
          w_state_nxt = S_DIV;
          w_count_nxt = CNT_W'(DIV_CYCLES - 1);
        end else begin
          w_state_nxt = S_MUL;
          w_count_nxt = CNT_W'(MUL_CYCLES - 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= 4'b0000;
      r_shift     <= 5'd0;
      r_shift_var <= 1'b0;
      r_hilo_rd   <= 2'b00;
      r_md_start  <= 1'b0;
      r_md_op     <= 2'b00;
      r_illegal   <= 1'b0;
    end else if (stall_in) begin
      r_md_start  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_ctrl  <= w_alu_ctrl;
      r_shift     <= w_shift;
      r_shift_var <= w_shift_var;
      r_hilo_rd   <= w_hilo_rd;
      r_md_start  <= w_md_start;
      r_md_op     <= w_md_op;
      r_illegal   <= w_illegal;
    end else begin
      r_out_valid <= 1'b0;
      r_alu_ctrl  <= 4'b0000;
      r_shift     <= 5'd0;
      r_shift_var <= 1'b0;
      r_hilo_rd   <= 2'b00;
      r_md_start  <= 1'b0;
      r_md_op     <= 2'b00;
      r_illegal   <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_ctrl  = r_alu_ctrl;
  assign shift     = r_shift;
  assign shift_var = r_shift_var;
  assign hilo_rd   = r_hilo_rd;
  assign md_start  = r_md_start;
  assign md_op     = r_md_op;
  assign illegal   = r_illegal;
  assign md_busy   = w_busy;
  assign md_done   = w_busy & w_cnt_zero;

endmodule

// File: tb/tb_alu_control_mdu.sv
// tb/tb_alu_control_mdu.sv - scoreboard bench for alu_control_mdu against a timeline model
module tb_alu_control_mdu;

  localparam int MULC = 4;
  localparam int DIVC = 32;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SLL = 4'b0011,
                         A_SRL = 4'b0100, A_SRA = 4'b0101, A_SUB = 4'b0110, A_SLT = 4'b0111,
                         A_XOR = 4'b1000, A_SLTU = 4'b1001, A_NOR = 4'b1100, A_NONE = 4'b1111;

  typedef struct packed {
    logic       ov;
    logic [3:0] alu;
    logic [4:0] sh;
    logic       sv;
    logic [1:0] hl;
    logic       ms;
    logic [1:0] mo;
    logic       ill;
    logic       busy;
    logic       done;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  aluop = 4'd0;
  logic [31:0] instruction = 32'd0;
  logic        stall_in = 1'b0;
  logic        stall_out, out_valid, shift_var, md_start, md_busy, md_done, illegal;
  logic [3:0]  alu_ctrl;
  logic [4:0]  shift;
  logic [1:0]  hilo_rd, md_op;

  alu_control_mdu #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .aluop(aluop), .instruction(instruction),
    .stall_in(stall_in), .stall_out(stall_out), .out_valid(out_valid), .alu_ctrl(alu_ctrl),
    .shift(shift), .shift_var(shift_var), .hilo_rd(hilo_rd), .md_start(md_start),
    .md_op(md_op), .md_busy(md_busy), .md_done(md_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  rec_t exp_q[$];
  bit   stall_q[$];
  int   total = 0;
  int   bad = 0;
  bit   started = 0;
  int   cyc = 0;
  int   md_end = -1;
  rec_t last = '0;
  bit   acc_o;

  // Reference decode: what an instruction should present on the outputs once accepted
  function automatic void ref_decode(input logic [3:0] op, input logic [31:0] ins,
                                     output rec_t r, output bit mdc, output bit launch);
    int f, sa;
    f = int'(ins[5:0]);
    sa = int'(ins[10:6]);
    r = '0;
    r.ov = 1'b1;
    r.alu = A_NONE;
    mdc = 0;
    launch = 0;
    if (op != 4'd2) begin
      case (op)
        4'd0: r.alu = A_ADD;
        4'd1: r.alu = A_SUB;
        4'd3: r.alu = A_AND;
        4'd4: begin r.alu = A_SLL; r.sh = 5'd16; end
        4'd5: r.alu = A_SLT;
        4'd6: r.alu = A_XOR;
        4'd7: r.alu = A_OR;
        4'd8: r.alu = A_SLTU;
        default: r.ill = 1'b1;
      endcase
    end else if (f == 0 || f == 2 || f == 3) begin
      r.alu = (f == 0) ? A_SLL : (f == 2) ? A_SRL : A_SRA;
      r.sh = 5'(sa);
    end else if (f == 4 || f == 6 || f == 7) begin
      r.alu = (f == 4) ? A_SLL : (f == 6) ? A_SRL : A_SRA;
      r.sv = 1'b1;
    end else if (f == 32 || f == 33) r.alu = A_ADD;
    else if (f == 34 || f == 35) r.alu = A_SUB;
    else if (f == 36) r.alu = A_AND;
    else if (f == 37) r.alu = A_OR;
    else if (f == 38) r.alu = A_XOR;
    else if (f == 39) r.alu = A_NOR;
    else if (f == 42) r.alu = A_SLT;
    else if (f == 43) r.alu = A_SLTU;
    else if (f == 16 || f == 18) begin
      mdc = 1;
      r.hl = (f == 16) ? 2'b01 : 2'b10;
    end else if (f >= 24 && f <= 27) begin
      mdc = 1;
      launch = 1;
      r.ms = 1'b1;
      r.mo = 2'(f - 24);
    end else r.ill = 1'b1;
  endfunction

  function automatic logic [31:0] rtype(input int f, input int sa);
    rtype = {16'h0, 5'd0, 5'(sa), 6'(f)};
  endfunction

  // One cycle of stimulus; the model tracks the MDU as "busy through cycle md_end"
  task automatic step(input bit rst, input bit v, input logic [3:0] op, input logic [31:0] ins,
                      input bit st, output bit acc);
    rec_t dec, nxt;
    bit mdc, launch, stall_exp;
    reset = rst;
    in_valid = v;
    aluop = op;
    instruction = ins;
    stall_in = st;
    ref_decode(op, ins, dec, mdc, launch);
    stall_exp = v && mdc && (cyc < md_end);
    stall_q.push_back(stall_exp);
    acc = !rst && v && !st && !stall_exp;
    if (rst) begin
      md_end = -1;
      nxt = '0;
    end else begin
      if (acc && launch) md_end = cyc + (dec.mo[1] ? DIVC : MULC);
      if (st) begin
        nxt = last;
        nxt.ms = 1'b0;
      end else if (acc) nxt = dec;
      else nxt = '0;
      nxt.busy = (md_end >= cyc + 1);
      nxt.done = (md_end == cyc + 1);
    end
    last = nxt;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'd0, 0, acc_o);
  endtask

  always @(negedge clk) begin
    rec_t e, a;
    bit s;
    if (started) begin
      a = {out_valid, alu_ctrl, shift, shift_var, hilo_rd, md_start, md_op, illegal, md_busy, md_done};
      if (stall_q.size() != 0) begin
        s = stall_q.pop_front();
        total++;
        if (stall_out !== s) begin
          bad++;
          $display("FAIL stall_out cyc=%0d got=%b want=%b", cyc, stall_out, s);
        end
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL underflow cyc=%0d got=%h want=none", cyc, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got ov=%b alu=%b sh=%0d sv=%b hl=%b ms=%b mo=%b ill=%b busy=%b done=%b want ov=%b alu=%b sh=%0d sv=%b hl=%b ms=%b mo=%b ill=%b busy=%b done=%b",
                   cyc, a.ov, a.alu, a.sh, a.sv, a.hl, a.ms, a.mo, a.ill, a.busy, a.done,
                   e.ov, e.alu, e.sh, e.sv, e.hl, e.ms, e.mo, e.ill, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fl[22] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 16, 18, 24, 25, 26, 27};
    logic [31:0] ins;
    logic [3:0] op;
    int f, guard;
    bit r, v, st;

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    started = 1;

    for (int i = 0; i < 3; i++) step(1, 0, 4'd0, 32'd0, 0, acc_o);
    step(0, 1, 4'd2, rtype(32, 0), 0, acc_o);
    step(0, 1, 4'd2, rtype(3, 7), 0, acc_o);
    step(0, 1, 4'd2, rtype(7, 9), 0, acc_o);
    step(0, 1, 4'd4, 32'h1234_5678, 0, acc_o);
    step(0, 1, 4'd11, rtype(32, 0), 0, acc_o);
    step(0, 1, 4'd2, rtype(9, 0), 0, acc_o);
    idle(1);

    step(0, 1, 4'd2, rtype(24, 0), 0, acc_o);
    for (int i = 0; i < 6; i++) step(0, 1, 4'd2, rtype(18, 0), 0, acc_o);
    idle(2);

    step(0, 1, 4'd2, rtype(26, 0), 0, acc_o);
    step(0, 1, 4'd2, rtype(32, 0), 0, acc_o);
    step(0, 1, 4'd2, rtype(38, 0), 0, acc_o);
    acc_o = 0;
    guard = 0;
    while (!acc_o && guard < 40) begin
      step(0, 1, 4'd2, rtype(27, 0), 0, acc_o);
      guard++;
    end
    total++;
    if (!acc_o) begin
      bad++;
      $display("FAIL divu_accept cyc=%0d got=stalled want=accepted", cyc);
    end
    while (md_end - cyc > 10) idle(1);
    step(1, 0, 4'd0, 32'd0, 0, acc_o);
    idle(3);

    step(0, 1, 4'd2, rtype(26, 0), 0, acc_o);
    idle(5);
    for (int i = 0; i < 3; i++) step(0, 1, 4'd2, rtype(32, 0), 1, acc_o);
    idle(30);

    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 9) < 8);
      st = ($urandom_range(0, 6) == 0);
      op = ($urandom_range(0, 2) != 0) ? 4'd2 : 4'($urandom_range(0, 15));
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : fl[$urandom_range(0, 21)];
      ins = $urandom();
      ins[5:0] = 6'(f);
      step(r, v, op, ins, st, acc_o);
    end

    @(negedge clk);
    #1;
    started = 0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
